// File: rtl/game_controller.sv
// game_controller: core state machine of the segment-runner game.
// Sequences IDLE -> READY -> PLAY -> OVER and scrolls pseudo-random obstacles
// across a 6-column field on every game tick. It also tracks the player lane,
// detects collisions and counts survived ticks. Every output comes straight
// from a flop.
module game_controller #(
    parameter int          TICK_DIV  = 4,      // clock cycles per game tick (>= 2)
    parameter logic [7:0]  LFSR_SEED = 8'hA5,  // non-zero LFSR reset value
    parameter int          SCORE_MAX = 9999    // GameScore saturation value
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LoggedIn,
    input  logic        GameButton,
    output logic [5:0]  FloorBits,
    output logic [5:0]  CeilingBits,
    output logic        PlayerPos,
    output logic        GameTick,
    output logic [3:0]  GameState,
    output logic [13:0] GameScore
);

    localparam int          CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [13:0] SCORE_TOP = 14'(SCORE_MAX);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_READY = 4'b0010,
        S_PLAY  = 4'b0100,
        S_OVER  = 4'b1000
    } state_t;

    state_t             state_q,    state_d;
    logic [5:0]         floor_q,    floor_d;
    logic [5:0]         ceil_q,     ceil_d;
    logic               pos_q,      pos_d;
    logic               tick_q,     tick_d;
    logic [13:0]        score_q,    score_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [7:0]         lfsr_q,     lfsr_d;
    logic               btn_prev_q, btn_prev_d;

    logic       btn_edge;
    logic [7:0] lfsr_adv;
    logic       cand_f;
    logic       cand_c;
    logic       entry_busy;
    logic       collision;

    // Helper terms: button edge, advanced LFSR, obstacle candidates, collision.
    // The candidates are taken from the freshly advanced LFSR value, so each
    // tick draws new random bits. A busy entry column suppresses both
    // candidates, which keeps obstacle columns at least one column apart.
    always_comb begin
        btn_edge   = GameButton & ~btn_prev_q;
        lfsr_adv   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        entry_busy = floor_q[0] | ceil_q[0];
        cand_f     = lfsr_adv[0] & lfsr_adv[1] & ~entry_busy;
        cand_c     = lfsr_adv[2] & lfsr_adv[3] & ~(lfsr_adv[0] & lfsr_adv[1]) & ~entry_busy;
        collision  = (~pos_q & floor_q[5]) | (pos_q & ceil_q[5]);
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        ceil_d     = ceil_q;
        pos_d      = pos_q;
        tick_d     = 1'b0;
        score_d    = score_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        btn_prev_d = GameButton;

        if (!LoggedIn) begin
            // Losing the session aborts anything and wipes the run.
            state_d = S_IDLE;
            floor_d = '0;
            ceil_d  = '0;
            pos_d   = 1'b0;
            score_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    floor_d = '0;
                    ceil_d  = '0;
                    pos_d   = 1'b0;
                    score_d = '0;
                    cnt_d   = '0;
                    state_d = S_READY;
                end
                S_READY: begin
                    // Score of the previous run stays visible until a new start.
                    floor_d = '0;
                    ceil_d  = '0;
                    if (btn_edge) begin
                        state_d = S_PLAY;
                        pos_d   = 1'b0;
                        score_d = '0;
                        cnt_d   = '0;
                    end
                end
                S_PLAY: begin
                    if (collision) begin
                        // The crash edge freezes everything: no tick, no toggle.
                        state_d = S_OVER;
                    end else begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            tick_d  = 1'b1;
                            lfsr_d  = lfsr_adv;
                            floor_d = {floor_q[4:0], cand_f};
                            ceil_d  = {ceil_q[4:0], cand_c};
                            if (score_q < SCORE_TOP) begin
                                score_d = score_q + 14'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (btn_edge) begin
                            pos_d = ~pos_q;
                        end
                    end
                end
                S_OVER: begin
                    if (btn_edge) begin
                        state_d = S_READY;
                        floor_d = '0;
                        ceil_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            ceil_q     <= '0;
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
            score_q    <= '0;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            ceil_q     <= ceil_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            score_q    <= score_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign FloorBits   = floor_q;
    assign CeilingBits = ceil_q;
    assign PlayerPos   = pos_q;
    assign GameTick    = tick_q;
    assign GameState   = state_q;
    assign GameScore   = score_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed testbench for game_controller with hand-derived expectations.
// The LFSR obstacle sequence from seed A5 is worked out by hand: the first
// floor obstacle enters at tick 6 and the second at tick 10. The first ceiling
// obstacle enters at tick 8. The floor obstacle of tick 6 reaches column 5 at
// tick 11.
module tb_game_controller;

    logic        clk;
    logic        rst;
    logic        li;
    logic        btn;
    logic [5:0]  floor_bits,  ceil_bits;
    logic        player_pos,  game_tick;
    logic [3:0]  game_state;
    logic [13:0] game_score;
    logic [5:0]  s_floor, s_ceil;
    logic        s_pos, s_tick;
    logic [3:0]  s_state;
    logic [13:0] s_score;

    int n_cmp = 0;
    int n_bad = 0;

    game_controller #(.TICK_DIV(4), .LFSR_SEED(8'hA5), .SCORE_MAX(9999)) dut (
        .Clk(clk), .Rst(rst), .LoggedIn(li), .GameButton(btn),
        .FloorBits(floor_bits), .CeilingBits(ceil_bits), .PlayerPos(player_pos),
        .GameTick(game_tick), .GameState(game_state), .GameScore(game_score)
    );

    game_controller #(.TICK_DIV(4), .LFSR_SEED(8'hA5), .SCORE_MAX(3)) dut_sat (
        .Clk(clk), .Rst(rst), .LoggedIn(li), .GameButton(btn),
        .FloorBits(s_floor), .CeilingBits(s_ceil), .PlayerPos(s_pos),
        .GameTick(s_tick), .GameState(s_state), .GameScore(s_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; li = 1'b0; btn = 1'b0;
        #12;
        rst = 1'b1;
        #1;
        if (game_state !== 4'b0001) begin $display("FAIL reset_state: got %b need %b", game_state, 4'b0001); n_bad++; end n_cmp++;
        if (floor_bits !== 6'b0 || ceil_bits !== 6'b0) begin $display("FAIL reset_fields: got %b/%b need 0/0", floor_bits, ceil_bits); n_bad++; end n_cmp++;
        if (player_pos !== 1'b0 || game_tick !== 1'b0) begin $display("FAIL reset_pos_tick: got %b/%b need 0/0", player_pos, game_tick); n_bad++; end n_cmp++;
        if (game_score !== 14'd0) begin $display("FAIL reset_score: got %0d need 0", game_score); n_bad++; end n_cmp++;
        step();
        rst = 1'b0;
        step();
        if (game_state !== 4'b0001) begin $display("FAIL idle_hold: got %b need %b", game_state, 4'b0001); n_bad++; end n_cmp++;
        $display("test_reset done");
    endtask

    task automatic test_start();
        li = 1'b1;
        step();
        if (game_state !== 4'b0010) begin $display("FAIL start_ready: got %b need %b", game_state, 4'b0010); n_bad++; end n_cmp++;
        btn = 1'b1;
        step();
        btn = 1'b0;
        if (game_state !== 4'b0100) begin $display("FAIL start_play: got %b need %b", game_state, 4'b0100); n_bad++; end n_cmp++;
        if (game_score !== 14'd0 || game_tick !== 1'b0) begin $display("FAIL start_score_tick: got %0d/%b need 0/0", game_score, game_tick); n_bad++; end n_cmp++;
        $display("test_start done");
    endtask

    // PLAY entered at cycle 0; ticks land on cycles 4, 8, 12.
    task automatic test_ticks();
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                if (game_tick !== (i == 3)) begin $display("FAIL tick_k%0d_i%0d: got %b need %b", k, i, game_tick, (i == 3)); n_bad++; end n_cmp++;
                if (i == 3) begin
                    if (game_score !== 14'(k)) begin $display("FAIL tick_score_%0d: got %0d need %0d", k, game_score, k); n_bad++; end n_cmp++;
                end
            end
            $display("tick %0d score %0d", k, game_score);
        end
    endtask

    // Starts at cycle 12 and ends at cycle 29.
    task automatic test_toggle();
        btn = 1'b1; step();
        if (player_pos !== 1'b1) begin $display("FAIL toggle_up: got %b need 1", player_pos); n_bad++; end n_cmp++;
        btn = 1'b0; step();
        if (player_pos !== 1'b1) begin $display("FAIL toggle_release: got %b need 1", player_pos); n_bad++; end n_cmp++;
        btn = 1'b1; step();
        if (player_pos !== 1'b0) begin $display("FAIL toggle_down: got %b need 0", player_pos); n_bad++; end n_cmp++;
        btn = 1'b0; step();
        if (game_tick !== 1'b1 || game_score !== 14'd4) begin $display("FAIL toggle_tick4: got %b/%0d need 1/4", game_tick, game_score); n_bad++; end n_cmp++;
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (player_pos !== 1'b1) begin $display("FAIL hold_cycle_%0d: got %b need 1", i, player_pos); n_bad++; end n_cmp++;
        end
        btn = 1'b0; step();
        if (player_pos !== 1'b1) begin $display("FAIL hold_release: got %b need 1", player_pos); n_bad++; end n_cmp++;
        btn = 1'b1; step();
        if (player_pos !== 1'b0 || game_tick !== 1'b1) begin $display("FAIL toggle_with_tick: got pos %b tick %b need 0/1", player_pos, game_tick); n_bad++; end n_cmp++;
        if (game_score !== 14'd7) begin $display("FAIL score_7: got %0d need 7", game_score); n_bad++; end n_cmp++;
        if (floor_bits !== 6'b000010 || ceil_bits !== 6'b000000) begin $display("FAIL fields_t7: got %b/%b need 000010/000000", floor_bits, ceil_bits); n_bad++; end n_cmp++;
        btn = 1'b0; step();
        $display("test_toggle done pos %b", player_pos);
    endtask

    // Starts at cycle 29 with the player on the floor.
    task automatic test_collision();
        logic [5:0] exp_f [4];
        logic [5:0] exp_c [4];
        exp_f[0] = 6'b000100; exp_c[0] = 6'b000001;
        exp_f[1] = 6'b001000; exp_c[1] = 6'b000010;
        exp_f[2] = 6'b010001; exp_c[2] = 6'b000100;
        exp_f[3] = 6'b100010; exp_c[3] = 6'b001000;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < ((t == 0) ? 3 : 4); i++) step();
            if (floor_bits !== exp_f[t] || ceil_bits !== exp_c[t]) begin $display("FAIL shift_t%0d: got %b/%b need %b/%b", t + 8, floor_bits, ceil_bits, exp_f[t], exp_c[t]); n_bad++; end n_cmp++;
            if (game_state !== 4'b0100 || game_score !== 14'(t + 8)) begin $display("FAIL play_t%0d: got %b/%0d need 0100/%0d", t + 8, game_state, game_score, t + 8); n_bad++; end n_cmp++;
            $display("tick %0d floor %b ceil %b", t + 8, floor_bits, ceil_bits);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (game_state !== 4'b1000 || game_score !== 14'd11 || game_tick !== 1'b0) begin $display("FAIL over_%0d: got %b/%0d/%b need 1000/11/0", i, game_state, game_score, game_tick); n_bad++; end n_cmp++;
            if (floor_bits !== 6'b100010 || ceil_bits !== 6'b001000) begin $display("FAIL over_frozen_%0d: got %b/%b need 100010/001000", i, floor_bits, ceil_bits); n_bad++; end n_cmp++;
        end
        btn = 1'b1; step();
        if (game_state !== 4'b0010 || game_score !== 14'd11) begin $display("FAIL over_to_ready: got %b/%0d need 0010/11", game_state, game_score); n_bad++; end n_cmp++;
        if (floor_bits !== 6'b0 || ceil_bits !== 6'b0) begin $display("FAIL ready_fields: got %b/%b need 0/0", floor_bits, ceil_bits); n_bad++; end n_cmp++;
        btn = 1'b0; step();
        $display("test_collision done score %0d", game_score);
    endtask

    task automatic test_logout();
        btn = 1'b1; step();
        if (game_state !== 4'b0100 || game_score !== 14'd0) begin $display("FAIL restart: got %b/%0d need 0100/0", game_state, game_score); n_bad++; end n_cmp++;
        btn = 1'b0; step();
        btn = 1'b1; step();
        if (player_pos !== 1'b1) begin $display("FAIL restart_toggle: got %b need 1", player_pos); n_bad++; end n_cmp++;
        btn = 1'b0; step();
        step();
        if (game_score !== 14'd1 || ceil_bits !== 6'b000001 || floor_bits !== 6'b0) begin $display("FAIL run2_t1: got %0d/%b/%b need 1/000001/000000", game_score, ceil_bits, floor_bits); n_bad++; end n_cmp++;
        li = 1'b0; step();
        if (game_state !== 4'b0001) begin $display("FAIL logout_state: got %b need 0001", game_state); n_bad++; end n_cmp++;
        if (game_score !== 14'd0 || player_pos !== 1'b0 || ceil_bits !== 6'b0 || floor_bits !== 6'b0) begin $display("FAIL logout_clear: got %0d/%b/%b/%b need all 0", game_score, player_pos, ceil_bits, floor_bits); n_bad++; end n_cmp++;
        step();
        if (game_state !== 4'b0001) begin $display("FAIL logout_hold: got %b need 0001", game_state); n_bad++; end n_cmp++;
        $display("test_logout done");
    endtask

    task automatic test_saturate();
        rst = 1'b1; #2; rst = 1'b0;
        li = 1'b1; step();
        btn = 1'b1; step();
        btn = 1'b0;
        if (s_state !== 4'b0100) begin $display("FAIL sat_play: got %b need 0100", s_state); n_bad++; end n_cmp++;
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 4; i++) step();
            if (s_score !== 14'((k > 3) ? 3 : k)) begin $display("FAIL sat_score_%0d: got %0d need %0d", k, s_score, (k > 3) ? 3 : k); n_bad++; end n_cmp++;
            if (game_score !== 14'(k)) begin $display("FAIL nosat_score_%0d: got %0d need %0d", k, game_score, k); n_bad++; end n_cmp++;
            $display("sat tick %0d score %0d / %0d", k, s_score, game_score);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ticks();
        test_toggle();
        test_collision();
        test_logout();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
